// File: rtl/adpcm_pkg.sv
// Shared constants and types for the IMA ADPCM step tracker.
package adpcm_pkg;

   localparam logic [6:0] MAX_INDEX = 7'd88;

   // IMA ADPCM step sizes, indexed by the step index 0..88.
   localparam logic [15:0] STEP_TABLE [0:88] = '{
      16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
      16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
      16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
      16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
      16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
      16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
      16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
      16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
      16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
      16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
      16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
      16'd32767
   };

   // Step index adjustment by code magnitude (code[2:0]).
   localparam logic signed [7:0] IDX_ADJ [0:7] = '{
      -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
   };

   typedef enum logic {
      WAIT_HDR = 1'b0,
      RUN      = 1'b1
   } state_t;

   // Saturating index update: signed add, then clamp into 0..MAX_INDEX.
   function automatic logic [6:0] adapt_index(input logic [6:0] index, input logic [2:0] mag);
      logic signed [7:0] sum;
      sum = $signed({1'b0, index}) + IDX_ADJ[mag];
      if (sum < 8'sd0)
         return 7'd0;
      else if (sum > $signed({1'b0, MAX_INDEX}))
         return MAX_INDEX;
      else
         return sum[6:0];
   endfunction

endpackage

// File: rtl/adpcm_step_tracker.sv
// Per-channel IMA ADPCM decoder state: holds predictor and step index,
// feeds the external inverse quantizer and registers its result.
module adpcm_step_tracker
   import adpcm_pkg::*;
#(
   parameter int BLOCK_CODES = 504,
   parameter int CNT_W       = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [15:0] hdr_predictor,
   input  logic [6:0]  hdr_index,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic [3:0]  code,
   output logic [3:0]  iq_code,
   output logic [15:0] iq_step_size,
   output logic [15:0] iq_prev_predicted,
   input  logic [15:0] iq_predicted,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sample,
   output logic        block_done
);

   localparam logic [CNT_W-1:0] LAST_CODE = CNT_W'(BLOCK_CODES - 1);

   state_t            state_reg, state_next;
   logic [15:0]       pred_reg, pred_next;
   logic [6:0]        index_reg, index_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              out_valid_reg, out_valid_next;
   logic [15:0]       out_sample_reg, out_sample_next;
   logic              slot_free;

   assign slot_free         = !out_valid_reg || out_ready;
   assign iq_code           = code;
   assign iq_step_size      = STEP_TABLE[index_reg];
   assign iq_prev_predicted = pred_reg;
   assign out_valid         = out_valid_reg;
   assign out_sample        = out_sample_reg;

   // Next-state, handshakes and datapath updates.
   always_comb begin
      state_next      = state_reg;
      pred_next       = pred_reg;
      index_next      = index_reg;
      count_next      = count_reg;
      out_valid_next  = out_valid_reg;
      out_sample_next = out_sample_reg;
      hdr_ready       = 1'b0;
      code_ready      = 1'b0;
      block_done      = 1'b0;

      // Held sample leaves when downstream takes it; a new accept reloads below.
      if (out_ready)
         out_valid_next = 1'b0;

      case (state_reg)
         WAIT_HDR: begin
            hdr_ready = slot_free && !rst;
            if (hdr_valid && hdr_ready) begin
               pred_next       = hdr_predictor;
               index_next      = (hdr_index > MAX_INDEX) ? MAX_INDEX : hdr_index;
               out_sample_next = hdr_predictor;
               out_valid_next  = 1'b1;
               count_next      = '0;
               state_next      = RUN;
            end
         end
         RUN: begin
            code_ready = slot_free && !rst;
            if (code_valid && code_ready) begin
               pred_next       = iq_predicted;
               out_sample_next = iq_predicted;
               out_valid_next  = 1'b1;
               index_next      = adapt_index(index_reg, code[2:0]);
               if (count_reg == LAST_CODE) begin
                  block_done = 1'b1;
                  count_next = '0;
                  state_next = WAIT_HDR;
               end else begin
                  count_next = count_reg + 1'b1;
               end
            end
         end
         default: state_next = WAIT_HDR;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= WAIT_HDR;
         pred_reg       <= '0;
         index_reg      <= '0;
         count_reg      <= '0;
         out_valid_reg  <= 1'b0;
         out_sample_reg <= '0;
      end else begin
         state_reg      <= state_next;
         pred_reg       <= pred_next;
         index_reg      <= index_next;
         count_reg      <= count_next;
         out_valid_reg  <= out_valid_next;
         out_sample_reg <= out_sample_next;
      end
   end

endmodule
